// File: rtl/bg_tile_fetcher.sv
// Background tile fetcher: walks one scanline of the BG tile map through the
// shared VRAM read port and streams 2-bit colour indices to the pixel pipe.
module bg_tile_fetcher #(
  parameter int LINE_PIXELS = 160,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_line_start,
  input  logic [7:0]  i_ly,
  input  logic [7:0]  i_scx,
  input  logic [7:0]  i_scy,
  input  logic        i_lcdc_map_sel,
  input  logic        i_lcdc_data_sel,
  input  logic        i_vram_busy,
  output logic [12:0] o_vram_addr,
  output logic        o_vram_rd,
  input  logic [7:0]  i_vram_q,
  output logic        o_pix_valid,
  output logic [1:0]  o_pix_data,
  input  logic        i_pix_ready,
  output logic        o_busy,
  output logic        o_line_done
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int OCW = $clog2(LINE_PIXELS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MAP_REQ, S_MAP_CAP, S_LO_REQ, S_LO_CAP, S_HI_REQ, S_HI_CAP, S_PUSH
  } state_t;

  state_t                       r_state;
  logic [7:0]                   r_row;
  logic [4:0]                   r_tile_x;
  logic [7:0]                   r_tile, r_lo, r_hi;
  logic                         r_busy, r_line_done;
  logic [2:0]                   r_discard;
  logic [OCW-1:0]               r_out_cnt;
  logic [FIFO_DEPTH-1:0][1:0]   r_fifo;
  logic [PW-1:0]                r_rd_ptr;
  logic [CW-1:0]                r_count;

  logic          w_req, w_nonempty, w_valid, w_disc_pop, w_out_pop, w_pop;
  logic          w_push, w_last;
  logic [11:0]   w_tile_base;
  logic [12:0]   w_addr;
  logic [PW-1:0] w_wr_ptr;

  // Signed mode maps tiles 0x00-0x7F to 0x1000 and 0x80-0xFF to 0x0800.
  assign w_tile_base = {~i_lcdc_data_sel & ~r_tile[7], r_tile, r_row[2:0]};

  // Read address follows the request state; it holds while the CPU owns VRAM.
  always_comb begin
    w_addr = 13'h0000;
    case (r_state)
      S_MAP_REQ: w_addr = {2'b11, i_lcdc_map_sel, r_row[7:3], r_tile_x};
      S_LO_REQ:  w_addr = {w_tile_base, 1'b0};
      S_HI_REQ:  w_addr = {w_tile_base, 1'b1};
      default:   w_addr = 13'h0000;
    endcase
  end

  assign w_req       = (r_state == S_MAP_REQ) || (r_state == S_LO_REQ) || (r_state == S_HI_REQ);
  assign o_vram_rd   = w_req & ~i_vram_busy;
  assign o_vram_addr = w_addr;

  // Scroll discards are popped internally and never shown to the consumer.
  assign w_nonempty  = (r_count != '0);
  assign w_disc_pop  = (r_discard != 3'd0) && w_nonempty;
  assign w_valid     = (r_discard == 3'd0) && w_nonempty;
  assign w_out_pop   = w_valid & i_pix_ready;
  assign w_pop       = w_disc_pop | w_out_pop;
  assign w_push      = (r_state == S_PUSH) && (r_count <= CW'(FIFO_DEPTH - 8));
  assign w_last      = w_out_pop && (r_out_cnt == OCW'(LINE_PIXELS - 1));
  assign w_wr_ptr    = r_rd_ptr + r_count[PW-1:0];

  assign o_pix_valid = w_valid;
  assign o_pix_data  = w_valid ? r_fifo[r_rd_ptr] : 2'b00;
  assign o_busy      = r_busy;
  assign o_line_done = r_line_done;

  // Fetch sequencer: map byte, low plane, high plane, then an 8-pixel push.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_row       <= 8'd0;
      r_tile_x    <= 5'd0;
      r_tile      <= 8'd0;
      r_lo        <= 8'd0;
      r_hi        <= 8'd0;
      r_busy      <= 1'b0;
      r_line_done <= 1'b0;
    end else begin
      r_line_done <= 1'b0;
      if (i_line_start) begin
        r_row    <= i_ly + i_scy;
        r_tile_x <= i_scx[7:3];
        r_busy   <= 1'b1;
        r_state  <= S_MAP_REQ;
      end else if (w_last) begin
        r_line_done <= 1'b1;
        r_busy      <= 1'b0;
        r_state     <= S_IDLE;
      end else begin
        case (r_state)
          S_MAP_REQ: if (!i_vram_busy) r_state <= S_MAP_CAP;
          S_MAP_CAP: begin r_tile <= i_vram_q; r_state <= S_LO_REQ; end
          S_LO_REQ:  if (!i_vram_busy) r_state <= S_LO_CAP;
          S_LO_CAP:  begin r_lo <= i_vram_q; r_state <= S_HI_REQ; end
          S_HI_REQ:  if (!i_vram_busy) r_state <= S_HI_CAP;
          S_HI_CAP:  begin r_hi <= i_vram_q; r_state <= S_PUSH; end
          S_PUSH: if (w_push) begin
            r_tile_x <= r_tile_x + 5'd1;
            r_state  <= S_MAP_REQ;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Pixel FIFO: 8-wide write of a decoded tile row, 1-wide read.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_fifo    <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_discard <= 3'd0;
      r_out_cnt <= '0;
    end else if (i_line_start) begin
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_discard <= i_scx[2:0];
      r_out_cnt <= '0;
    end else if (w_last) begin
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_out_cnt <= r_out_cnt + OCW'(1);
    end else begin
      if (w_push) begin
        for (int i = 0; i < 8; i++)
          r_fifo[w_wr_ptr + PW'(i)] <= {r_hi[7-i], r_lo[7-i]};
      end
      r_count <= r_count + (w_push ? CW'(8) : CW'(0)) - (w_pop ? CW'(1) : CW'(0));
      if (w_pop)      r_rd_ptr  <= r_rd_ptr + PW'(1);
      if (w_disc_pop) r_discard <= r_discard - 3'd1;
      if (w_out_pop)  r_out_cnt <= r_out_cnt + OCW'(1);
    end
  end

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Directed bench for bg_tile_fetcher with a 1-cycle-latency VRAM model.
module tb_bg_tile_fetcher;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ls = 1'b0, map_sel = 1'b0, data_sel = 1'b1, vbusy = 1'b0, rdy = 1'b1;
  logic [7:0]  ly = 8'd0, scx = 8'd0, scy = 8'd0, vq = 8'd0;
  logic [12:0] addr;
  logic        rd, pv, bsy, ld;
  logic [1:0]  pd;

  logic [7:0] mem [0:8191];
  int n_chk = 0, n_err = 0, cyc = 0;
  int exp_pix [0:159];
  int npix, ndone, first_v, done_c, nrd;

  always #5 clk = ~clk;

  // VRAM: registered read, data one cycle after the request
  always @(posedge clk) if (rd) vq <= mem[addr];

  bg_tile_fetcher #(.LINE_PIXELS(160), .FIFO_DEPTH(16)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_line_start(ls),
    .i_ly(ly), .i_scx(scx), .i_scy(scy),
    .i_lcdc_map_sel(map_sel), .i_lcdc_data_sel(data_sel),
    .i_vram_busy(vbusy), .o_vram_addr(addr), .o_vram_rd(rd), .i_vram_q(vq),
    .o_pix_valid(pv), .o_pix_data(pd), .i_pix_ready(rdy),
    .o_busy(bsy), .o_line_done(ld)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
  endtask

  // tile 1 row 0 = lo F0 / hi CC on every map slot of map 0x1800
  task automatic basic_mem();
    clr_mem();
    for (int i = 0; i < 32; i++) mem[13'h1800 + i] = 8'h01;
    mem[13'h0010] = 8'hF0;
    mem[13'h0011] = 8'hCC;
    for (int i = 0; i < 160; i++) begin
      case (i % 8)
        0, 1:    exp_pix[i] = 3;
        2, 3:    exp_pix[i] = 1;
        4, 5:    exp_pix[i] = 2;
        default: exp_pix[i] = 0;
      endcase
    end
  endtask

  // line_start sampled at edge 0; returns positioned inside cycle 1
  task automatic start_line(input logic [7:0] l, input logic [7:0] sx, input logic [7:0] sy,
                            input logic ms, input logic ds);
    @(posedge clk); #1;
    ly = l; scx = sx; scy = sy; map_sel = ms; data_sel = ds; ls = 1'b1;
    @(posedge clk); #1;
    ls = 1'b0; cyc = 1;
  endtask

  // consume pixels until line_done, stop_pix accepted, or the cycle budget ends;
  // pix_ready is dropped for cycles [off_lo, off_hi)
  task automatic drain(input string tag, input int max_cyc, input int stop_pix,
                       input int off_lo, input int off_hi);
    npix = 0; ndone = 0; first_v = -1; done_c = -1; nrd = 0;
    while (cyc < max_cyc && ndone == 0 && npix < stop_pix) begin
      rdy = !(cyc >= off_lo && cyc < off_hi);
      @(negedge clk);
      if (cyc >= off_lo && cyc < off_hi) begin
        if (rd) nrd++;
        chk($sformatf("%s hold_valid c%0d", tag, cyc), pv, 1);
        chk($sformatf("%s hold_data c%0d", tag, cyc), pd, 3);
      end
      if (ld) begin
        ndone++; done_c = cyc;
        chk($sformatf("%s done_valid", tag), pv, 0);
        chk($sformatf("%s done_busy", tag), bsy, 0);
      end
      if (pv) begin
        if (first_v < 0) first_v = cyc;
        if (rdy) begin
          if (npix < 160) chk($sformatf("%s pix%0d", tag, npix), pd, exp_pix[npix]);
          npix++;
        end
      end
      adv();
    end
    rdy = 1'b1;
  endtask

  initial begin
    #2;
    chk("rst rd", rd, 0);     chk("rst addr", addr, 0);
    chk("rst valid", pv, 0);  chk("rst data", pd, 0);
    chk("rst busy", bsy, 0);  chk("rst done", ld, 0);
    @(negedge clk); rst_n = 1'b1;

    // basic line: reads at cycles 1/3/5, first pixel cycle 8, done at 168
    basic_mem();
    start_line(8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("basic rd c%0d", c), rd, (c == 1 || c == 3 || c == 5));
      chk($sformatf("basic valid c%0d", c), pv, 0);
      if (c == 1) chk("basic map addr", addr, 13'h1800);
      if (c == 1) chk("basic busy", bsy, 1);
      if (c == 3) chk("basic lo addr", addr, 13'h0010);
      if (c == 5) chk("basic hi addr", addr, 13'h0011);
      adv();
    end
    drain("basic", 400, 1000, -1, -1);
    chk("basic first", first_v, 8);
    chk("basic npix", npix, 160);
    chk("basic done_cyc", done_c, 168);

    // VRAM stall during LO_REQ (cycles 3..6)
    start_line(8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      vbusy = (c >= 3 && c <= 6);
      @(negedge clk);
      if (c >= 3) begin
        chk($sformatf("stall rd c%0d", c), rd, (c == 7));
        chk($sformatf("stall addr c%0d", c), addr, 13'h0010);
      end
      chk($sformatf("stall valid c%0d", c), pv, 0);
      adv();
    end
    vbusy = 1'b0;
    drain("stall", 400, 1000, -1, -1);
    chk("stall first", first_v, 12);
    chk("stall npix", npix, 160);
    chk("stall done_cyc", done_c, 172);

    // scroll + map wrap: row 0x12, tile_x 31, discard 5
    clr_mem();
    mem[13'h1C5F] = 8'h02;
    mem[13'h0024] = 8'h05;
    mem[13'h0025] = 8'h03;
    for (int i = 0; i < 160; i++) exp_pix[i] = 0;
    exp_pix[0] = 1; exp_pix[1] = 2; exp_pix[2] = 3;
    start_line(8'h07, 8'hFD, 8'h0B, 1'b1, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("scroll valid c%0d", c), pv, 0);
      if (c == 1) chk("scroll map addr", addr, 13'h1C5F);
      if (c == 3) chk("scroll lo addr", addr, 13'h0024);
      if (c == 8) begin
        chk("scroll wrap rd", rd, 1);
        chk("scroll wrap addr", addr, 13'h1C40);
      end
      adv();
    end
    drain("scroll", 400, 1000, -1, -1);
    chk("scroll first", first_v, 13);
    chk("scroll npix", npix, 160);
    chk("scroll done_cyc", done_c, 173);

    // signed tile addressing, row 5
    clr_mem();
    mem[13'h1800] = 8'h80;
    mem[13'h1801] = 8'h7F;
    start_line(8'd5, 8'd0, 8'd0, 1'b0, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 3)  begin chk("signed rd80", rd, 1); chk("signed addr80", addr, 13'h080A); end
      if (c == 10) begin chk("signed rd7F", rd, 1); chk("signed addr7F", addr, 13'h17FA); end
      adv();
    end

    // asynchronous reset mid-line clears outputs without waiting for a clock
    chk("mid busy before rst", bsy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst rd", rd, 0);     chk("arst addr", addr, 0);
    chk("arst valid", pv, 0);  chk("arst data", pd, 0);
    chk("arst busy", bsy, 0);  chk("arst done", ld, 0);
    @(negedge clk); rst_n = 1'b1;

    // backpressure: pix_ready low for cycles 8..27, FIFO fills and fetch stops
    basic_mem();
    start_line(8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    drain("bp", 600, 1000, 8, 28);
    chk("bp first", first_v, 8);
    chk("bp reads in stall", nrd, 6);
    chk("bp npix", npix, 160);
    chk("bp done_cyc", done_c, 188);

    // restart at pixel 50: no line_done, fresh line of 160
    start_line(8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    drain("rs1", 400, 50, -1, -1);
    chk("rs1 npix", npix, 50);
    chk("rs1 no done", ndone, 0);
    start_line(8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    drain("rs2", 400, 1000, -1, -1);
    chk("rs2 first", first_v, 8);
    chk("rs2 npix", npix, 160);
    chk("rs2 done_cyc", done_c, 168);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
